// File: rtl/sdram_access_arbiter.sv
// sdram_access_arbiter: shares one SDRAM command port between PORTS single-word requesters
// Ports:
//   clk, reset (async, active-low)
//   reqValid/reqWrite/reqAddr/reqWdata -> per-port requests (packed, port i at [i*W +: W])
//   reqAccept -> one-hot accept pulse; urgent -> strict priority for port 0
//   cmdValid/cmdReady/cmdWrite/cmdAddr/cmdWdata -> controller command handshake
//   rdValid/rdData -> in-order read returns; rspValid/rspData -> routed read data
//   tagCount -> reads outstanding; tagError -> sticky read return with nothing outstanding
module sdram_access_arbiter #(
  parameter int PORTS     = 3,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int TAG_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [PORTS-1:0]             reqValid,
  input  logic [PORTS-1:0]             reqWrite,
  input  logic [PORTS*ADDR_W-1:0]      reqAddr,
  input  logic [PORTS*DATA_W-1:0]      reqWdata,
  output logic [PORTS-1:0]             reqAccept,
  output logic [PORTS-1:0]             rspValid,
  output logic [DATA_W-1:0]            rspData,
  input  logic                         urgent,
  output logic                         cmdValid,
  input  logic                         cmdReady,
  output logic                         cmdWrite,
  output logic [ADDR_W-1:0]            cmdAddr,
  output logic [DATA_W-1:0]            cmdWdata,
  input  logic                         rdValid,
  input  logic [DATA_W-1:0]            rdData,
  output logic [$clog2(TAG_DEPTH):0]   tagCount,
  output logic                         tagError
);
  localparam int PW = $clog2(PORTS);
  localparam int TW = $clog2(TAG_DEPTH);
  typedef enum logic {IDLE, ISSUE} state_t;
  state_t state;
  logic [PW-1:0] lastGrant, winner, idx, headTag;
  logic [PW-1:0] tagMem [TAG_DEPTH];
  logic [TW-1:0] wrPtr, rdPtr;
  logic [PORTS-1:0] eligible;
  logic found, grant, push, pop, tagFull;
  // reads are masked while every tag is in use; writes never need a tag
  assign tagFull  = tagCount == (TW+1)'(TAG_DEPTH);
  assign eligible = reqValid & (reqWrite | {PORTS{!tagFull}});
  // round-robin scan starting just after the last grant, with port 0 override on urgent
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = lastGrant;
    for (int k = 0; k < PORTS; k++) begin
      idx = (idx == PW'(PORTS-1)) ? '0 : idx + 1'b1;
      if (eligible[idx] && !found) begin
        winner = idx;
        found  = 1'b1;
      end
    end
    if (urgent && eligible[0]) winner = '0;
  end
  assign grant     = state == IDLE && |eligible;
  assign reqAccept = grant ? PORTS'(1) << winner : '0;
  assign push      = grant && !reqWrite[winner];
  assign pop       = rdValid && tagCount != '0;
  assign headTag   = tagMem[rdPtr];
  always_ff @(posedge clk) if (push) tagMem[wrPtr] <= winner;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lastGrant <= PW'(PORTS-1);
      cmdValid  <= 1'b0;
      cmdWrite  <= 1'b0;
      cmdAddr   <= '0;
      cmdWdata  <= '0;
      wrPtr     <= '0;
      rdPtr     <= '0;
      tagCount  <= '0;
      tagError  <= 1'b0;
      rspValid  <= '0;
      rspData   <= '0;
    end else begin
      if (grant) begin
        state     <= ISSUE;
        cmdValid  <= 1'b1;
        lastGrant <= winner;
        cmdWrite  <= reqWrite[winner];
        cmdAddr   <= reqAddr[winner*ADDR_W +: ADDR_W];
        cmdWdata  <= reqWdata[winner*DATA_W +: DATA_W];
      end else if (state == ISSUE && cmdReady) begin
        state    <= IDLE;
        cmdValid <= 1'b0;
      end
      wrPtr    <= wrPtr + TW'(push);
      rdPtr    <= rdPtr + TW'(pop);
      tagCount <= tagCount + (TW+1)'(push) - (TW+1)'(pop);
      rspValid <= pop ? PORTS'(1) << headTag : '0;
      if (pop) rspData <= rdData;
      if (rdValid && tagCount == '0) tagError <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sdram_access_arbiter.sv
// tb_sdram_access_arbiter: directed self-checking bench for sdram_access_arbiter
module tb_sdram_access_arbiter;
  localparam int PORTS = 3, ADDR_W = 24, DATA_W = 16, TAG_DEPTH = 4;
  logic clk = 1'b0, reset = 1'b0;
  logic [PORTS-1:0] reqValid = '0, reqWrite = '0, reqAccept, rspValid;
  logic [PORTS*ADDR_W-1:0] reqAddr = {24'h000300, 24'h000200, 24'h000100};
  logic [PORTS*DATA_W-1:0] reqWdata = {16'h3333, 16'h2222, 16'h1111};
  logic [DATA_W-1:0] rspData, cmdWdata, rdData = '0;
  logic urgent = 1'b0, cmdValid, cmdReady = 1'b1, cmdWrite, rdValid = 1'b0, tagError;
  logic [ADDR_W-1:0] cmdAddr;
  logic [2:0] tagCount;
  int tests = 0, failed = 0;
  always #5 clk = ~clk;
  sdram_access_arbiter #(.PORTS(PORTS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .reset(reset), .reqValid(reqValid), .reqWrite(reqWrite), .reqAddr(reqAddr),
    .reqWdata(reqWdata), .reqAccept(reqAccept), .rspValid(rspValid), .rspData(rspData),
    .urgent(urgent), .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
    .cmdAddr(cmdAddr), .cmdWdata(cmdWdata), .rdValid(rdValid), .rdData(rdData),
    .tagCount(tagCount), .tagError(tagError));

  task automatic test_reset;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (cmdValid !== 1'b0) begin failed++; $display("FAIL reset_cmdValid: got %b expected 0", cmdValid); end
    tests++; if ({cmdWrite, cmdAddr, cmdWdata} !== '0) begin failed++; $display("FAIL reset_cmd: got %b/%h/%h expected 0/0/0", cmdWrite, cmdAddr, cmdWdata); end
    tests++; if (tagCount !== 3'd0 || tagError !== 1'b0) begin failed++; $display("FAIL reset_tags: got count %0d err %b expected 0 0", tagCount, tagError); end
    tests++; if (rspValid !== 3'b000 || rspData !== 16'h0) begin failed++; $display("FAIL reset_rsp: got %b/%h expected 000/0000", rspValid, rspData); end
  endtask

  task automatic test_round_robin;
    logic [2:0] expAcc, expRsp;
    @(negedge clk);
    reset = 1'b1; reqValid = 3'b111; reqWrite = 3'b000; cmdReady = 1'b1; urgent = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) @(negedge clk);
      rdValid = c % 2 == 1;
      rdData = 16'(16'h0100 + c);
      #1;
      expAcc = (c % 2 == 1) ? 3'b000 : 3'(3'b001 << ((c / 2) % 3));
      tests++; if (reqAccept !== expAcc) begin failed++; $display("FAIL rr_accept c=%0d: got %b expected %b", c, reqAccept, expAcc); end
      tests++; if (cmdValid !== 1'(c % 2)) begin failed++; $display("FAIL rr_cmdValid c=%0d: got %b expected %0d", c, cmdValid, c % 2); end
      if (c % 2 == 1) begin
        tests++; if (cmdAddr !== 24'((((c - 1) / 2) % 3 + 1) << 8)) begin failed++; $display("FAIL rr_cmdAddr c=%0d: got %h", c, cmdAddr); end
      end else begin
        expRsp = (c == 0) ? 3'b000 : 3'(3'b001 << (((c - 2) / 2) % 3));
        tests++; if (rspValid !== expRsp) begin failed++; $display("FAIL rr_rspValid c=%0d: got %b expected %b", c, rspValid, expRsp); end
        if (c > 0) begin
          tests++; if (rspData !== 16'(16'h0100 + c - 1)) begin failed++; $display("FAIL rr_rspData c=%0d: got %h expected %h", c, rspData, 16'(16'h0100 + c - 1)); end
        end
      end
    end
    @(negedge clk); reqValid = '0; rdValid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_urgent;
    reqWrite = 3'b111; reqValid = 3'b001; #1;
    tests++; if (reqAccept !== 3'b001) begin failed++; $display("FAIL urg_first: got %b expected 001", reqAccept); end
    @(negedge clk); reqValid = 3'b000;
    @(negedge clk); reqValid = 3'b101; urgent = 1'b1; #1;
    tests++; if (reqAccept !== 3'b001) begin failed++; $display("FAIL urg_priority: got %b expected 001", reqAccept); end
    @(negedge clk); reqValid = 3'b000; urgent = 1'b0;
    @(negedge clk); reqValid = 3'b101; #1;
    tests++; if (reqAccept !== 3'b100) begin failed++; $display("FAIL urg_off_rr: got %b expected 100", reqAccept); end
    @(negedge clk); reqValid = 3'b001; urgent = 1'b1; #1;
    tests++; if (reqAccept !== 3'b000 || cmdAddr !== 24'h000300) begin failed++; $display("FAIL urg_no_preempt: got %b/%h expected 000/000300", reqAccept, cmdAddr); end
    @(negedge clk); #1;
    tests++; if (reqAccept !== 3'b001) begin failed++; $display("FAIL urg_after_issue: got %b expected 001", reqAccept); end
    @(negedge clk); reqValid = '0; urgent = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tag_full;
    reqWrite = 3'b000; reqValid = 3'b010;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      tests++; if (reqAccept !== ((k % 2 == 0) ? 3'b010 : 3'b000)) begin failed++; $display("FAIL full_fill k=%0d: got %b", k, reqAccept); end
    end
    @(negedge clk); #1;
    tests++; if (tagCount !== 3'd4 || reqAccept !== 3'b000) begin failed++; $display("FAIL full_mask: got count %0d accept %b expected 4 000", tagCount, reqAccept); end
    @(negedge clk); reqValid = 3'b110; reqWrite = 3'b100; #1;
    tests++; if (reqAccept !== 3'b100) begin failed++; $display("FAIL full_write_ok: got %b expected 100", reqAccept); end
    @(negedge clk); reqValid = 3'b010; reqWrite = 3'b000; #1;
    tests++; if (cmdWrite !== 1'b1 || cmdWdata !== 16'h3333) begin failed++; $display("FAIL full_write_cmd: got %b/%h expected 1/3333", cmdWrite, cmdWdata); end
    @(negedge clk); rdValid = 1'b1; rdData = 16'hBEEF; #1;
    tests++; if (reqAccept !== 3'b000) begin failed++; $display("FAIL full_still_masked: got %b expected 000", reqAccept); end
    @(negedge clk); rdValid = 1'b0; #1;
    tests++; if (tagCount !== 3'd3 || reqAccept !== 3'b010) begin failed++; $display("FAIL full_reopen: got count %0d accept %b expected 3 010", tagCount, reqAccept); end
    tests++; if (rspValid !== 3'b010 || rspData !== 16'hBEEF) begin failed++; $display("FAIL full_rsp: got %b/%h expected 010/beef", rspValid, rspData); end
    @(negedge clk); reqValid = '0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); rdValid = 1'b1; end
    @(negedge clk); rdValid = 1'b0; #1;
    tests++; if (tagCount !== 3'd0 || tagError !== 1'b0) begin failed++; $display("FAIL full_drain: got count %0d err %b expected 0 0", tagCount, tagError); end
  endtask

  task automatic test_routing;
    int ord [3] = '{2, 0, 1};
    reqWrite = 3'b000;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk); reqValid = 3'(3'b001 << ord[j]); #1;
      tests++; if (reqAccept !== 3'(3'b001 << ord[j])) begin failed++; $display("FAIL route_accept j=%0d: got %b", j, reqAccept); end
      @(negedge clk); reqValid = '0;
    end
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); rdValid = j < 3; rdData = 16'(16'hA001 + j); #1;
      if (j == 0) begin
        tests++; if (rspValid !== 3'b000) begin failed++; $display("FAIL route_early: got %b expected 000", rspValid); end
      end else begin
        tests++; if (rspValid !== 3'(3'b001 << ord[j-1]) || rspData !== 16'(16'hA000 + j)) begin failed++; $display("FAIL route_rsp j=%0d: got %b/%h expected %b/%h", j, rspValid, rspData, 3'(3'b001 << ord[j-1]), 16'(16'hA000 + j)); end
      end
    end
    @(negedge clk); #1;
    tests++; if (rspValid !== 3'b000 || tagCount !== 3'd0) begin failed++; $display("FAIL route_end: got %b count %0d expected 000 0", rspValid, tagCount); end
  endtask

  task automatic test_backpressure;
    @(negedge clk); reqValid = 3'b001; reqWrite = 3'b001; cmdReady = 1'b0; #1;
    tests++; if (reqAccept !== 3'b001) begin failed++; $display("FAIL bp_accept: got %b expected 001", reqAccept); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); reqValid = 3'b010; reqWrite = 3'b011; #1;
      tests++; if (cmdValid !== 1'b1 || cmdAddr !== 24'h000100 || cmdWdata !== 16'h1111 || reqAccept !== 3'b000) begin failed++; $display("FAIL bp_hold k=%0d: got v%b a%h d%h acc%b", k, cmdValid, cmdAddr, cmdWdata, reqAccept); end
    end
    @(negedge clk); cmdReady = 1'b1; #1;
    tests++; if (cmdValid !== 1'b1 || reqAccept !== 3'b000) begin failed++; $display("FAIL bp_release: got v%b acc%b expected 1 000", cmdValid, reqAccept); end
    @(negedge clk); #1;
    tests++; if (cmdValid !== 1'b0 || reqAccept !== 3'b010) begin failed++; $display("FAIL bp_idle: got v%b acc%b expected 0 010", cmdValid, reqAccept); end
    @(negedge clk); reqValid = '0; #1;
    tests++; if (cmdAddr !== 24'h000200 || cmdWdata !== 16'h2222) begin failed++; $display("FAIL bp_next_cmd: got %h/%h expected 000200/2222", cmdAddr, cmdWdata); end
    @(negedge clk);
  endtask

  task automatic test_error_reset;
    @(negedge clk); rdValid = 1'b1; reqWrite = '0;
    @(negedge clk); rdValid = 1'b0; #1;
    tests++; if (tagError !== 1'b1 || rspValid !== 3'b000 || tagCount !== 3'd0) begin failed++; $display("FAIL err_spurious: got err %b rsp %b count %0d expected 1 000 0", tagError, rspValid, tagCount); end
    @(negedge clk); reqValid = 3'b001; cmdReady = 1'b0; #1;
    tests++; if (reqAccept !== 3'b001) begin failed++; $display("FAIL err_accept: got %b expected 001", reqAccept); end
    @(negedge clk); reqValid = '0; #1;
    tests++; if (cmdValid !== 1'b1 || tagCount !== 3'd1) begin failed++; $display("FAIL err_issue: got v%b count %0d expected 1 1", cmdValid, tagCount); end
    #2 reset = 1'b0; #1;
    tests++; if (cmdValid !== 1'b0 || tagCount !== 3'd0 || tagError !== 1'b0) begin failed++; $display("FAIL err_async_reset: got v%b count %0d err %b expected 0 0 0", cmdValid, tagCount, tagError); end
    @(negedge clk); reset = 1'b1; cmdReady = 1'b1; rdValid = 1'b1;
    @(negedge clk); rdValid = 1'b0; #1;
    tests++; if (tagError !== 1'b1 || rspValid !== 3'b000) begin failed++; $display("FAIL err_stale_read: got err %b rsp %b expected 1 000", tagError, rspValid); end
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_urgent;
    test_tag_full;
    test_routing;
    test_backpressure;
    test_error_reset;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
